// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES
// slices, one slice per clock, carry registered between slices.
module pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int C = WIDTH / STAGES;
   localparam int L = STAGES - 1;

   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  s_q   [STAGES];
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] cy_q;
   logic              cm_q;

   logic [WIDTH-1:0]  a_src [STAGES];
   logic [WIDTH-1:0]  b_src [STAGES];
   logic [WIDTH-1:0]  s_src [STAGES];
   logic [WIDTH-1:0]  s_nxt [STAGES];
   logic [C:0]        slice [STAGES];
   logic [STAGES-1:0] v_src;
   logic [STAGES-1:0] c_src;
   logic [STAGES-1:0] cy_nxt;
   logic              cm_nxt;
   logic              stall;

   // A full output register with no taker freezes the entire pipe, bubbles included.
   assign stall    = v_q[L] & ~out_ready;
   assign in_ready = ~stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         // Subtraction is folded in at capture so every slice is a plain add.
         assign a_src[k] = a;
         assign b_src[k] = sub ? ~b : b;
         assign c_src[k] = sub ? 1'b1 : c_in;
         assign s_src[k] = '0;
         assign v_src[k] = in_valid;
      end else begin : g_body
         assign a_src[k] = a_q[k-1];
         assign b_src[k] = b_q[k-1];
         assign c_src[k] = cy_q[k-1];
         assign s_src[k] = s_q[k-1];
         assign v_src[k] = v_q[k-1];
      end

      assign slice[k] = {1'b0, a_src[k][k*C +: C]}
                      + {1'b0, b_src[k][k*C +: C]}
                      + {{C{1'b0}}, c_src[k]};

      // Bits at and above slice k of s_src are always zero, so OR merges the new slice.
      assign s_nxt[k]  = s_src[k] | (WIDTH'(slice[k][C-1:0]) << (k*C));
      assign cy_nxt[k] = slice[k][C];
   end

   // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
   assign cm_nxt = a_src[L][WIDTH-1] ^ b_src[L][WIDTH-1] ^ s_nxt[L][WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '{default: '0};
         b_q  <= '{default: '0};
         s_q  <= '{default: '0};
         v_q  <= '0;
         cy_q <= '0;
         cm_q <= 1'b0;
      end else if (!stall) begin
         a_q  <= a_src;
         b_q  <= b_src;
         s_q  <= s_nxt;
         v_q  <= v_src;
         cy_q <= cy_nxt;
         cm_q <= cm_nxt;
      end
   end

   assign out_valid = v_q[L];
   assign sum       = s_q[L];
   assign c_out     = cy_q[L];
   assign ovf       = cm_q ^ cy_q[L];

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: four instances (8/2, 32/1, 32/4, 32/32) share one
// stimulus stream; each has its own scoreboard fed by an arithmetic model.
module tb_pipe_adder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] a_drv;
   logic [31:0] b_drv;
   logic        c_in;
   logic        sub;

   logic [3:0]  ir;
   logic [3:0]  ov;
   logic [3:0]  co;
   logic [3:0]  of;
   logic [7:0]  sum8;
   logic [31:0] sum1;
   logic [31:0] sum4;
   logic [31:0] sum32;

   int checks   = 0;
   int failures = 0;
   int cyc_cnt  = 0;

   int widths [4] = '{8, 32, 32, 32};
   int stages [4] = '{2, 1, 4, 32};

   typedef struct packed {
      logic [33:0] r;
      int          cyc;
      int          st;
   } ent_t;

   ent_t        sbq [4][$];
   int          stall_cnt  [4];
   logic        prev_stall [4];
   logic [34:0] held       [4];
   logic [33:0] last8;
   logic        got8;

   pipe_adder #(.WIDTH(8), .STAGES(2)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .a(a_drv[7:0]), .b(b_drv[7:0]), .c_in(c_in), .sub(sub),
      .out_valid(ov[0]), .out_ready(out_ready), .sum(sum8), .c_out(co[0]), .ovf(of[0]));

   pipe_adder #(.WIDTH(32), .STAGES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .a(a_drv), .b(b_drv), .c_in(c_in), .sub(sub),
      .out_valid(ov[1]), .out_ready(out_ready), .sum(sum1), .c_out(co[1]), .ovf(of[1]));

   pipe_adder #(.WIDTH(32), .STAGES(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
      .a(a_drv), .b(b_drv), .c_in(c_in), .sub(sub),
      .out_valid(ov[2]), .out_ready(out_ready), .sum(sum4), .c_out(co[2]), .ovf(of[2]));

   pipe_adder #(.WIDTH(32), .STAGES(32)) u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
      .a(a_drv), .b(b_drv), .c_in(c_in), .sub(sub),
      .out_valid(ov[3]), .out_ready(out_ready), .sum(sum32), .c_out(co[3]), .ovf(of[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: integer arithmetic on the operand values, signed range test for ovf.
   function automatic logic [33:0] model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                         input logic tc, input logic ts);
      longint full, half, mask, ua, ub, sa, sb, tot, sres;
      logic   cout, ovfl;
      full = longint'(1) << w;
      half = full >> 1;
      mask = full - 1;
      ua   = longint'(ta) & mask;
      ub   = longint'(tb) & mask;
      sa   = (ua >= half) ? ua - full : ua;
      sb   = (ub >= half) ? ub - full : ub;
      if (ts) begin
         tot  = ua - ub + full;
         sres = sa - sb;
      end else begin
         tot  = ua + ub + longint'(tc);
         sres = sa + sb + longint'(tc);
      end
      cout = (tot >= full);
      ovfl = (sres >= half) || (sres < -half);
      return {ovfl, cout, 32'(tot & mask)};
   endfunction

   function automatic logic [33:0] obs(input int k);
      case (k)
         0:       return {of[0], co[0], 24'd0, sum8};
         1:       return {of[1], co[1], sum1};
         2:       return {of[2], co[2], sum4};
         default: return {of[3], co[3], sum32};
      endcase
   endfunction

   task automatic clear_sb();
      for (int k = 0; k < 4; k++) begin
         sbq[k].delete();
         prev_stall[k] = 1'b0;
      end
   endtask

   // Called at posedge+1 with inputs already driven; samples mid-cycle, then advances one edge.
   task automatic cycle();
      logic [33:0] cur;
      logic        stl;
      ent_t        e;
      #1;
      for (int k = 0; k < 4; k++) begin
         cur = obs(k);
         stl = ov[k] & ~out_ready;
         checks++;
         assert (ir[k] === !stl) else begin
            failures++;
            $error("FAIL in_ready dut%0d observed=%b expected=%b", k, ir[k], !stl);
         end
         if (prev_stall[k]) begin
            checks++;
            assert ({ov[k], cur} === held[k]) else begin
               failures++;
               $error("FAIL hold dut%0d observed=%h expected=%h", k, {ov[k], cur}, held[k]);
            end
         end
         if (ov[k] && out_ready) begin
            checks++;
            if (sbq[k].size() == 0) begin
               failures++;
               $error("FAIL unexpected_result dut%0d observed=%h expected=none", k, cur);
            end else begin
               e = sbq[k].pop_front();
               assert (cur === e.r) else begin
                  failures++;
                  $error("FAIL result dut%0d observed=%h expected=%h", k, cur, e.r);
               end
               if (k == 0) begin
                  last8 = cur;
                  got8  = 1'b1;
               end
               if (stall_cnt[k] == e.st) begin
                  checks++;
                  assert (cyc_cnt - e.cyc === stages[k]) else begin
                     failures++;
                     $error("FAIL latency dut%0d observed=%0d expected=%0d", k, cyc_cnt - e.cyc, stages[k]);
                  end
               end
            end
         end
         if (in_valid && ir[k])
            sbq[k].push_back('{r: model(widths[k], a_drv, b_drv, c_in, sub), cyc: cyc_cnt, st: stall_cnt[k]});
         if (stl) stall_cnt[k]++;
         prev_stall[k] = stl;
         held[k]       = {ov[k], cur};
      end
      @(posedge clk);
      cyc_cnt++;
      #1;
   endtask

   task automatic rand_op();
      case ($urandom_range(0, 7))
         0:       a_drv = 32'h8000_0000;
         1:       a_drv = 32'h7FFF_FFFF;
         2:       a_drv = 32'hFFFF_FFFF;
         default: a_drv = $urandom;
      endcase
      b_drv = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      c_in  = 1'($urandom_range(0, 1));
      sub   = 1'($urandom_range(0, 1));
   endtask

   task automatic directed(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts,
                           input logic [7:0] es, input logic ec, input logic eo, input string tag);
      logic [33:0] exp8;
      exp8      = {eo, ec, 24'd0, es};
      a_drv     = {8'($urandom), 16'($urandom), ta};
      b_drv     = {8'($urandom), 16'($urandom), tb};
      c_in      = tc;
      sub       = ts;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      got8      = 1'b0;
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 8 && !got8; i++) cycle();
      checks++;
      assert (got8 === 1'b1 && last8 === exp8) else begin
         failures++;
         $error("FAIL %s observed=%h got=%b expected=%h", tag, last8, got8, exp8);
      end
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0 && sbq[3].size() == 0)
            break;
         cycle();
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         assert (sbq[k].size() === 0) else begin
            failures++;
            $error("FAIL drain dut%0d observed=%0d pending expected=0", k, sbq[k].size());
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a_drv     = '0;
      b_drv     = '0;
      c_in      = 1'b0;
      sub       = 1'b0;
      last8     = '0;
      got8      = 1'b0;
      for (int k = 0; k < 4; k++) begin
         stall_cnt[k] = 0;
         held[k]      = '0;
      end
      clear_sb();

      #22;
      checks++;
      assert ({ov[0], co[0], of[0], sum8} === 11'd0 && ir[0] === 1'b1) else begin
         failures++;
         $error("FAIL reset_state observed=%b_%h in_ready=%b expected=0_00 in_ready=1",
                {ov[0], co[0], of[0]}, sum8, ir[0]);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Two ops in flight, then an asynchronous reset mid-cycle.
      rand_op(); in_valid = 1'b1; cycle();
      rand_op(); cycle();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      assert (ov === 4'b0000 && sum8 === 8'd0 && sum4 === 32'd0 && sum32 === 32'd0) else begin
         failures++;
         $error("FAIL async_reset observed ov=%b sum8=%h sum4=%h expected ov=0000 sums=0", ov, sum8, sum4);
      end
      clear_sb();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) cycle();

      directed(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add_slice_carry");
      directed(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap");
      directed(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "add_cin_ovf");
      directed(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_borrow");
      directed(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");
      directed(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_borrow_cin1");
      directed(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf_cin1");
      drain();

      // Back-to-back stream, then three cycles of backpressure with in_valid held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rand_op();
         cycle();
      end
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_op();
         cycle();
      end
      drain();

      // Random valid/ready toggling across all parameter sets.
      for (int i = 0; i < 1600; i++) begin
         rand_op();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
